// File: rtl/lamp_fade_scheduler.sv
// Soft-fade duty generator for six traffic-lamp PWM channels; one shared step engine swept round-robin on tick.
// Optional LAMP_SNAP_OFF_EN: a channel whose target is 0 drops straight to 0 when serviced.

module lamp_fade_lane #(
  parameter int DBITS     = 8,
  parameter int DIM_LEVEL = 64
) (
  input  logic             req,
  input  logic             night,
  input  logic [DBITS-1:0] duty,
  output logic [DBITS-1:0] target,
  output logic             match
);
  localparam logic [DBITS-1:0] FULL = '1;
  localparam logic [DBITS-1:0] DIM  = DBITS'(DIM_LEVEL);

  assign target = !req ? '0 : (night ? DIM : FULL);
  assign match  = (duty == target);
endmodule

module lamp_fade_scheduler #(
  parameter int NCH       = 6,
  parameter int DBITS     = 8,
  parameter int STEP      = 16,
  parameter int DIM_LEVEL = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic [NCH-1:0]       lamp_req,
  input  logic                 night,
  output logic [NCH*DBITS-1:0] duty,
  output logic                 sweep_done,
  output logic                 settled,
  output logic                 overrun
);
  localparam int IDXW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [DBITS:0]  STEP_W = (DBITS+1)'(STEP);
  localparam logic [IDXW-1:0] LAST   = IDXW'(NCH-1);

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t                     state_q, state_d;
  logic [IDXW-1:0]            idx_q, idx_d;
  logic                       done_q, done_d;
  logic                       ovr_q, ovr_d;
  logic                       upd;
  logic [NCH-1:0][DBITS-1:0]  duty_q;
  logic [NCH-1:0][DBITS-1:0]  tgt;
  logic [NCH-1:0]             match;
  logic [DBITS-1:0]           duty_nxt;
  logic [DBITS:0]             cur_w, tgt_w;

  // Target and settle compare per channel; the step engine itself is shared.
  generate
    for (genvar i = 0; i < NCH; i++) begin : g_lane
      lamp_fade_lane #(.DBITS(DBITS), .DIM_LEVEL(DIM_LEVEL)) u_lane (
        .req    (lamp_req[i]),
        .night  (night),
        .duty   (duty_q[i]),
        .target (tgt[i]),
        .match  (match[i])
      );
    end
  endgenerate

  // Widened by one bit so the +/-STEP never wraps before the clamp.
  always_comb begin
    cur_w    = {1'b0, duty_q[idx_q]};
    tgt_w    = {1'b0, tgt[idx_q]};
    duty_nxt = duty_q[idx_q];
    if (cur_w < tgt_w)
      duty_nxt = (tgt_w - cur_w <= STEP_W) ? tgt[idx_q] : DBITS'(cur_w + STEP_W);
    else if (cur_w > tgt_w)
      duty_nxt = (cur_w - tgt_w <= STEP_W) ? tgt[idx_q] : DBITS'(cur_w - STEP_W);
`ifdef LAMP_SNAP_OFF_EN
    if (tgt[idx_q] == '0)
      duty_nxt = '0;
`else
`endif
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    ovr_d   = ovr_q;
    upd     = 1'b0;
    case (state_q)
      IDLE: begin
        if (tick) begin
          state_d = SWEEP;
          idx_d   = '0;
        end
      end
      SWEEP: begin
        upd = 1'b1;
        if (tick) ovr_d = 1'b1;
        if (idx_q == LAST) begin
          state_d = IDLE;
          idx_d   = '0;
          done_d  = 1'b1;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
      duty_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
      if (upd) duty_q[idx_q] <= duty_nxt;
    end
  end

  assign duty       = duty_q;
  assign sweep_done = done_q;
  assign overrun    = ovr_q;
  assign settled    = (state_q == IDLE) && (&match);
endmodule

// File: tb/tb_lamp_fade_scheduler.sv
// Directed bench for lamp_fade_scheduler with a cycle-level reference model checked every cycle.
module tb_lamp_fade_scheduler;
  localparam int NCH = 6, DBITS = 8, STEP = 16, DIM = 64, FULL = 255;

  logic                 clk = 0;
  logic                 rst = 1;
  logic                 tick = 0;
  logic [NCH-1:0]       lamp_req = '0;
  logic                 night = 0;
  logic [NCH*DBITS-1:0] duty;
  logic                 sweep_done, settled, overrun;

  int checks = 0;
  int failures = 0;

  lamp_fade_scheduler #(.NCH(NCH), .DBITS(DBITS), .STEP(STEP), .DIM_LEVEL(DIM)) dut (
    .clk(clk), .rst(rst), .tick(tick), .lamp_req(lamp_req), .night(night),
    .duty(duty), .sweep_done(sweep_done), .settled(settled), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Reference model: sweep position counted in edges since the accepted tick.
  int  m_duty[NCH];
  bit  m_busy, m_done, m_ovr, armed;
  int  m_pos;

  function automatic int tgt_of(int i);
    if (!lamp_req[i]) return 0;
    return night ? DIM : FULL;
  endfunction

  function automatic int step_to(int d, int t);
`ifdef LAMP_SNAP_OFF_EN
    if (t == 0) return 0;
`endif
    if (d < t) return (d + STEP > t) ? t : d + STEP;
    if (d > t) return (d - STEP < t) ? t : d - STEP;
    return d;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      foreach (m_duty[i]) m_duty[i] = 0;
      m_busy = 0; m_done = 0; m_ovr = 0; m_pos = 0; armed = 1;
    end else begin
      m_done = 0;
      if (m_busy) begin
        if (tick) m_ovr = 1;
        m_duty[m_pos] = step_to(m_duty[m_pos], tgt_of(m_pos));
        if (m_pos == NCH-1) begin m_busy = 0; m_done = 1; end
        else m_pos++;
      end else if (tick) begin
        m_busy = 1; m_pos = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      logic [NCH*DBITS-1:0] exp_bus;
      bit exp_set;
      exp_set = !m_busy;
      for (int i = 0; i < NCH; i++) begin
        exp_bus[i*DBITS +: DBITS] = DBITS'(m_duty[i]);
        if (m_duty[i] != tgt_of(i)) exp_set = 0;
      end
      checks++;
      if (duty !== exp_bus) begin failures++; $display("FAIL duty_bus act=%h exp=%h t=%0t", duty, exp_bus, $time); end
      checks++;
      if (sweep_done !== m_done) begin failures++; $display("FAIL sweep_done act=%b exp=%b t=%0t", sweep_done, m_done, $time); end
      checks++;
      if (settled !== exp_set) begin failures++; $display("FAIL settled act=%b exp=%b t=%0t", settled, exp_set, $time); end
      checks++;
      if (overrun !== m_ovr) begin failures++; $display("FAIL overrun act=%b exp=%b t=%0t", overrun, m_ovr, $time); end
    end
  end

  function automatic int ch(int i);
    return int'(duty[i*DBITS +: DBITS]);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s act=%0d exp=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Raise tick so it is sampled at the next edge, then idle out the gap.
  task automatic tick_gap(input int gap);
    tick = 1; step(1); tick = 0; step(gap - 1);
  endtask

  initial begin
    step(2);
    rst = 0;
    step(5);
    chk("reset_settled", settled, 1);
    chk("reset_overrun", overrun, 0);
    chk("reset_duty", int'(duty == '0), 1);

    // Ramp channel 0 up from 0
    lamp_req = 6'b000001;
    tick = 1; step(1); tick = 0;
    chk("ramp_pre_edge", ch(0), 0);
    step(1);
    chk("ramp_latency", ch(0), 16);
    step(8);
    for (int s = 2; s <= 15; s++) tick_gap(10);
    chk("ramp_15", ch(0), 240);
    tick_gap(10);
    chk("ramp_16", ch(0), 255);
    chk("ramp_settled", settled, 1);
    chk("ramp_others", ch(5), 0);

    // Ordering and sweep_done timing
    lamp_req = 6'b111111;
    tick = 1; step(1); tick = 0;
    step(1);
    chk("order_ch1_k1", ch(1), 0);
    step(1);
    chk("order_ch1_k2", ch(1), 16);
    chk("order_ch5_k2", ch(5), 0);
    step(4);
    chk("order_done_k6", sweep_done, 1);
    chk("order_ch5_k6", ch(5), 16);
    step(1);
    chk("order_done_k7", sweep_done, 0);
    step(3);
    for (int s = 0; s < 15; s++) tick_gap(10);
    chk("all_full", int'(duty == '1), 1);

    // Night dim 255 -> 64
    night = 1;
    for (int s = 0; s < 11; s++) tick_gap(10);
    chk("dim_11", ch(2), 79);
    tick_gap(10);
    chk("dim_12", ch(2), 64);
    chk("dim_settled", settled, 1);

    // Overrun: second tick 3 edges into the sweep
    tick = 1; step(1); tick = 0; step(2);
    tick = 1; step(1); tick = 0; step(8);
    chk("overrun_set", overrun, 1);

    // Back to full, then turn channel 3 off
    night = 0;
    for (int s = 0; s < 12; s++) tick_gap(10);
    chk("refull_ch3", ch(3), 255);
    lamp_req = 6'b110111;
    tick_gap(10);
`ifdef LAMP_SNAP_OFF_EN
    chk("turnoff_ch3", ch(3), 0);
`else
    chk("turnoff_ch3", ch(3), 239);
`endif
    chk("overrun_sticky", overrun, 1);

    // Reset sampled at edge k+2 of a sweep
    tick = 1; step(1); tick = 0;
    step(1);
    rst = 1; step(1);
    chk("midrst_duty", int'(duty == '0), 1);
    chk("midrst_overrun", overrun, 0);
    rst = 0; step(6);
    chk("midrst_no_done", sweep_done, 0);

    // Tick coincident with reset is lost
    rst = 1; tick = 1; step(1);
    rst = 0; tick = 0; step(8);
    chk("rst_tick_duty", int'(duty == '0), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
